div_sched: RTL

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_pkg.sv | 11 +
 rtl/div_phase_cnt.sv | 25 ++
 rtl/div_sched.sv | 136 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared scheduler state type and constants for the divided-clock block.
package div_pkg;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   localparam int MIN_DIV   = 2;
   localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/div_phase_cnt.sv
// div_phase_cnt: phase counter with terminal-count flag; wraps to 0 on terminal count.
module div_phase_cnt
   import div_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] len,
   output logic             tc
);
   logic [CNT_W-1:0] cnt;

   assign tc = (cnt == len - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/div_sched.sv
// div_sched: start/stop clock divider with a one-deep ratio queue applied at falling boundaries.
// Define DIVSCHED_CHK_EN to reject ratios below MIN_DIV (cfg_err pulse) instead of clamping them.
module div_sched
   import div_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DEFAULT_DIV = 20
) (
   input  logic             I_CLK,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             O_CLK,
   output logic             O_TICK,
   output logic             busy,
   output logic [CNT_W-1:0] cur_div
);
   localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DIV);
   localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEFAULT_DIV);

   state_t           state, state_nxt;
   logic             clk_nxt, tick_nxt, cnt_clr, tc, apply;
   logic             pend_vld, xfer, too_small, accept;
   logic [CNT_W-1:0] pend, pend_d;
   logic [CNT_W-1:0] hi_len, lo_len, len;

   // High phase gets the smaller half so odd ratios spend the extra cycle low.
   assign hi_len = cur_div >> 1;
   assign lo_len = cur_div - hi_len;
   assign len    = O_CLK ? hi_len : lo_len;

   div_phase_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk (I_CLK),
      .rst (rst),
      .clr (cnt_clr),
      .en  (state != IDLE),
      .len (len),
      .tc  (tc)
   );

   always_ff @(posedge I_CLK) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clk_nxt   = O_CLK;
      tick_nxt  = 1'b0;
      cnt_clr   = 1'b0;
      apply     = 1'b0;
      case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            apply   = pend_vld;
            if (start && !stop) begin
               state_nxt = RUN;
               clk_nxt   = 1'b1;
               tick_nxt  = 1'b1;
            end
         end
         RUN: begin
            if (O_CLK) begin
               // Falling boundary: the only point a queued ratio may take effect.
               if (tc) begin
                  clk_nxt = 1'b0;
                  apply   = pend_vld;
                  if (stop) state_nxt = IDLE;
               end else if (stop) begin
                  state_nxt = STOPPING;
               end
            end else if (stop) begin
               state_nxt = IDLE;
            end else if (tc) begin
               clk_nxt  = 1'b1;
               tick_nxt = 1'b1;
            end
         end
         STOPPING: begin
            if (tc) begin
               clk_nxt   = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign cfg_ready = !pend_vld;
   assign xfer      = cfg_valid && cfg_ready;
   assign too_small = cfg_div < MIN_D;
   assign busy      = (state != IDLE);

`ifdef DIVSCHED_CHK_EN
   logic err_q;

   assign accept  = xfer && !too_small;
   assign pend_d  = cfg_div;
   assign cfg_err = err_q;

   always_ff @(posedge I_CLK) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= xfer && too_small;
   end
`else
   assign accept  = xfer;
   assign pend_d  = too_small ? MIN_D : cfg_div;
   assign cfg_err = 1'b0;
`endif

   // apply needs a full slot and accept needs an empty one, so they never coincide.
   always_ff @(posedge I_CLK) begin
      if (rst) begin
         O_CLK    <= 1'b0;
         O_TICK   <= 1'b0;
         pend_vld <= 1'b0;
         pend     <= '0;
         cur_div  <= DEF_D;
      end else begin
         O_CLK  <= clk_nxt;
         O_TICK <= tick_nxt;
         if (apply) begin
            cur_div  <= pend;
            pend_vld <= 1'b0;
         end
         if (accept) begin
            pend     <= pend_d;
            pend_vld <= 1'b1;
         end
      end
   end
endmodule
